// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared opcodes, WriteDst codes and state types for the register-file sequencer
package regfile_ctrl_pkg;

  localparam logic [3:0] OP_ALU  = 4'b0000;
  localparam logic [3:0] OP_SWAP = 4'b1000;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] FN_MUL = 4'b0100;
  localparam logic [3:0] FN_DIV = 4'b0101;

  localparam logic [1:0] WD_RD     = 2'b00;
  localparam logic [1:0] WD_RD_RS  = 2'b01;
  localparam logic [1:0] WD_RD_R15 = 2'b10;
  localparam logic [1:0] WD_NONE   = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_SWAP,
    CL_BEQ,
    CL_JMP,
    CL_HALT,
    CL_ILLEGAL
  } instr_class_e;

endpackage

// File: rtl/regfile_instr_decode.sv
// rtl/regfile_instr_decode.sv - combinational decode of the latched instruction word
module regfile_instr_decode
  import regfile_ctrl_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [15:0]     ir,
  output instr_class_e    cls,
  output logic [1:0]      wd_code,
  output logic            multicycle,
  output logic            illegal,
  output logic [PC_W-1:0] branch_off,
  output logic [PC_W-1:0] jmp_target
);

  always_comb begin
    cls        = CL_ILLEGAL;
    wd_code    = WD_NONE;
    multicycle = 1'b0;
    illegal    = 1'b0;
    case (ir[15:12])
      OP_ALU: begin
        cls = CL_ALU;
        if (ir[3:0] == FN_MUL || ir[3:0] == FN_DIV) begin
          multicycle = 1'b1;
          wd_code    = WD_RD_R15;
        end else begin
          wd_code    = WD_RD;
        end
      end
      OP_SWAP: begin
        cls     = CL_SWAP;
        wd_code = WD_RD_RS;
      end
      OP_BEQ:  cls = CL_BEQ;
      OP_JMP:  cls = CL_JMP;
      OP_HALT: cls = CL_HALT;
      default: illegal = 1'b1;
    endcase
  end

  assign branch_off = {{(PC_W-8){ir[7]}}, ir[7:0]};
  assign jmp_target = {{(PC_W-12){1'b0}}, ir[11:0]};

endmodule

// File: rtl/regfile_seq_ctrl.sv
// rtl/regfile_seq_ctrl.sv - multi-cycle fetch/decode/exec/writeback sequencer for the 16x16 register file
module regfile_seq_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_ack,
  output logic [3:0]      read_add1,
  output logic [3:0]      read_add2,
  output logic [1:0]      write_dst,
  input  logic [15:0]     data1,
  input  logic [15:0]     data15,
  output logic [3:0]      alu_op,
  output logic            alu_start,
  input  logic            alu_done,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            imem_req_q, imem_req_d;
  logic [3:0]      read_add1_q, read_add1_d;
  logic [3:0]      read_add2_q, read_add2_d;
  logic [1:0]      write_dst_q, write_dst_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            alu_start_q, alu_start_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;

  instr_class_e    dec_cls;
  logic [1:0]      dec_wd;
  logic            dec_multi;
  logic            dec_illegal;
  logic [PC_W-1:0] dec_off;
  logic [PC_W-1:0] dec_jmp;

  regfile_instr_decode #(.PC_W(PC_W)) u_decode (
    .ir         (ir_q),
    .cls        (dec_cls),
    .wd_code    (dec_wd),
    .multicycle (dec_multi),
    .illegal    (dec_illegal),
    .branch_off (dec_off),
    .jmp_target (dec_jmp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      imem_req_q  <= 1'b0;
      read_add1_q <= '0;
      read_add2_q <= '0;
      write_dst_q <= WD_NONE;
      alu_op_q    <= '0;
      alu_start_q <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      imem_req_q  <= imem_req_d;
      read_add1_q <= read_add1_d;
      read_add2_q <= read_add2_d;
      write_dst_q <= write_dst_d;
      alu_op_q    <= alu_op_d;
      alu_start_q <= alu_start_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
    end
  end

  // An ack only counts while our own request is visible, so stale acks after reset are dropped.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_req_q && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (dec_cls)
          CL_ALU, CL_SWAP: state_d = ST_EXEC;
          CL_BEQ: begin
            pc_d    = (data1 == data15) ? pc_q + dec_off : pc_q + PC_W'(1);
            state_d = ST_FETCH;
          end
          CL_JMP: begin
            pc_d    = dec_jmp;
            state_d = ST_FETCH;
          end
          CL_HALT: state_d = ST_HALT;
          default: begin
            pc_d    = pc_q + PC_W'(1);
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_EXEC: begin
        if (!dec_multi || alu_done) state_d = ST_WB;
      end
      ST_WB: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Outputs are registered from the next state so each one is valid for the whole state it belongs to.
  always_comb begin
    imem_req_d  = (state_d == ST_FETCH);
    read_add1_d = read_add1_q;
    read_add2_d = read_add2_q;
    alu_op_d    = alu_op_q;
    if (state_q == ST_FETCH && state_d == ST_DECODE) begin
      read_add1_d = imem_rdata[11:8];
      read_add2_d = imem_rdata[7:4];
      alu_op_d    = (imem_rdata[15:12] == OP_ALU) ? imem_rdata[3:0] : 4'h0;
    end
    write_dst_d = (state_d == ST_WB) ? dec_wd : WD_NONE;
    alu_start_d = (state_q == ST_DECODE) && (state_d == ST_EXEC) && dec_multi;
    halted_d    = halted_q | (state_d == ST_HALT);
    illegal_d   = illegal_q | ((state_q == ST_DECODE) && dec_illegal);
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign read_add1 = read_add1_q;
  assign read_add2 = read_add2_q;
  assign write_dst = write_dst_q;
  assign alu_op    = alu_op_q;
  assign alu_start = alu_start_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// tb/tb_regfile_seq_ctrl.sv - directed self-checking bench for regfile_seq_ctrl
module tb_regfile_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic [3:0]  read_add1, read_add2, alu_op;
  logic [1:0]  write_dst;
  logic [15:0] data1 = '0;
  logic [15:0] data15 = '0;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [15:0] pc;
  logic        halted, illegal;

  int vectors = 0;
  int miscompares = 0;

  regfile_seq_ctrl #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .read_add1  (read_add1),
    .read_add2  (read_add2),
    .write_dst  (write_dst),
    .data1      (data1),
    .data15     (data15),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .pc         (pc),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Wait for the request, hold off wait_cycles, then ack for one cycle; returns in the DECODE cycle.
  task automatic fetch(input logic [15:0] instr, input int wait_cycles);
    int n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_req_timeout imem_req=%b exp=1", imem_req);
    end
    repeat (wait_cycles) @(negedge clk);
    imem_rdata = instr;
    imem_ack   = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_imem_req got=%b exp=0", imem_req); end
    vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL rst_pc got=%h exp=0000", pc); end
    vectors++; if (write_dst !== 2'b11) begin miscompares++; $display("FAIL rst_write_dst got=%b exp=11", write_dst); end
    vectors++; if ({read_add1, read_add2, alu_op} !== 12'h000) begin miscompares++; $display("FAIL rst_addr_op got=%h exp=000", {read_add1, read_add2, alu_op}); end
    vectors++; if ({alu_start, halted, illegal} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got=%b exp=000", {alu_start, halted, illegal}); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin miscompares++; $display("FAIL rst_first_req got=%b/%h exp=1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_alu();
    fetch(16'h0120, 2);
    vectors++; if (read_add1 !== 4'd1 || read_add2 !== 4'd2) begin miscompares++; $display("FAIL alu_dec_addr got=%0d,%0d exp=1,2", read_add1, read_add2); end
    vectors++; if (write_dst !== 2'b11 || alu_op !== 4'h0) begin miscompares++; $display("FAIL alu_dec_wd_op got=%b/%h exp=11/0", write_dst, alu_op); end
    @(negedge clk);
    vectors++; if (write_dst !== 2'b11) begin miscompares++; $display("FAIL alu_exec_wd got=%b exp=11", write_dst); end
    @(negedge clk);
    vectors++; if (write_dst !== 2'b00 || read_add1 !== 4'd1 || read_add2 !== 4'd2 || pc !== 16'h0000) begin
      miscompares++; $display("FAIL alu_wb got wd=%b ra1=%0d ra2=%0d pc=%h exp 00,1,2,0000", write_dst, read_add1, read_add2, pc);
    end
    @(negedge clk);
    vectors++; if (pc !== 16'h0001 || write_dst !== 2'b11 || imem_req !== 1'b1 || imem_addr !== 16'h0001) begin
      miscompares++; $display("FAIL alu_next_fetch got pc=%h wd=%b req=%b addr=%h exp 0001,11,1,0001", pc, write_dst, imem_req, imem_addr);
    end
  endtask

  task automatic test_swap();
    logic [1:0] exp_wd [4];
    exp_wd[0] = 2'b11; exp_wd[1] = 2'b11; exp_wd[2] = 2'b01; exp_wd[3] = 2'b11;
    fetch(16'h8340, 0);
    for (int i = 0; i < 4; i++) begin
      vectors++; if (write_dst !== exp_wd[i]) begin miscompares++; $display("FAIL swap_wd_cycle%0d got=%b exp=%b", i, write_dst, exp_wd[i]); end
      if (i == 2) begin
        vectors++; if (read_add1 !== 4'd3 || read_add2 !== 4'd4) begin miscompares++; $display("FAIL swap_wb_addr got=%0d,%0d exp=3,4", read_add1, read_add2); end
      end
      if (i < 3) @(negedge clk);
    end
    vectors++; if (pc !== 16'h0002) begin miscompares++; $display("FAIL swap_pc got=%h exp=0002", pc); end
  endtask

  task automatic test_mul();
    fetch(16'h0564, 1);
    vectors++; if (alu_op !== 4'h4 || alu_start !== 1'b0) begin miscompares++; $display("FAIL mul_dec got op=%h start=%b exp 4,0", alu_op, alu_start); end
    @(negedge clk);
    vectors++; if (alu_start !== 1'b1) begin miscompares++; $display("FAIL mul_start_pulse got=%b exp=1", alu_start); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++; if (alu_start !== 1'b0 || write_dst !== 2'b11) begin miscompares++; $display("FAIL mul_wait%0d got start=%b wd=%b exp 0,11", i, alu_start, write_dst); end
    end
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    vectors++; if (write_dst !== 2'b10 || pc !== 16'h0002) begin miscompares++; $display("FAIL mul_wb got wd=%b pc=%h exp 10,0002", write_dst, pc); end
    @(negedge clk);
    vectors++; if (pc !== 16'h0003 || write_dst !== 2'b11) begin miscompares++; $display("FAIL mul_pc got pc=%h wd=%b exp 0003,11", pc, write_dst); end
  endtask

  task automatic test_branch();
    fetch(16'hC005, 0);
    @(negedge clk);
    vectors++; if (pc !== 16'h0005) begin miscompares++; $display("FAIL jmp_pc got=%h exp=0005", pc); end
    data1 = 16'h0F00; data15 = 16'h0F00;
    fetch(16'h41FE, 0);
    vectors++; if (write_dst !== 2'b11 || read_add1 !== 4'd1) begin miscompares++; $display("FAIL beq_dec got wd=%b ra1=%0d exp 11,1", write_dst, read_add1); end
    @(negedge clk);
    vectors++; if (pc !== 16'h0003) begin miscompares++; $display("FAIL beq_taken_pc got=%h exp=0003", pc); end
    fetch(16'hC005, 0);
    @(negedge clk);
    data15 = 16'h0000;
    fetch(16'h41FE, 0);
    @(negedge clk);
    vectors++; if (pc !== 16'h0006) begin miscompares++; $display("FAIL beq_not_taken_pc got=%h exp=0006", pc); end
  endtask

  task automatic test_illegal();
    fetch(16'h2000, 0);
    vectors++; if (illegal !== 1'b0 || write_dst !== 2'b11) begin miscompares++; $display("FAIL ill_dec got ill=%b wd=%b exp 0,11", illegal, write_dst); end
    @(negedge clk);
    vectors++; if (illegal !== 1'b1 || pc !== 16'h0007 || write_dst !== 2'b11) begin
      miscompares++; $display("FAIL ill_after got ill=%b pc=%h wd=%b exp 1,0007,11", illegal, pc, write_dst);
    end
  endtask

  task automatic test_pc_wrap();
    fetch(16'hC000, 0);
    @(negedge clk);
    data1 = 16'h0005; data15 = 16'h0005;
    fetch(16'h41FF, 0);
    @(negedge clk);
    vectors++; if (pc !== 16'hFFFF || imem_addr !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_beq_neg got pc=%h addr=%h exp FFFF", pc, imem_addr); end
    fetch(16'h0120, 0);
    repeat (3) @(negedge clk);
    vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL wrap_inc got pc=%h exp=0000", pc); end
  endtask

  task automatic test_reset_mid_exec();
    fetch(16'hC00A, 0);
    @(negedge clk);
    fetch(16'h0564, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++; if (pc !== 16'h0000 || imem_req !== 1'b0) begin miscompares++; $display("FAIL rstx_pc_req got pc=%h req=%b exp 0000,0", pc, imem_req); end
    vectors++; if (write_dst !== 2'b11 || alu_start !== 1'b0 || illegal !== 1'b0) begin
      miscompares++; $display("FAIL rstx_outs got wd=%b start=%b ill=%b exp 11,0,0", write_dst, alu_start, illegal);
    end
    @(negedge clk);
    rst = 1'b0;
    alu_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++; if (write_dst !== 2'b11) begin miscompares++; $display("FAIL rstx_no_write%0d got=%b exp=11", i, write_dst); end
    end
    alu_done = 1'b0;
    vectors++; if (pc !== 16'h0000 || imem_req !== 1'b1) begin miscompares++; $display("FAIL rstx_fetch got pc=%h req=%b exp 0000,1", pc, imem_req); end
  endtask

  task automatic test_halt();
    fetch(16'hF000, 0);
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_early got=%b exp=0", halted); end
    @(negedge clk);
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_set got=%b exp=1", halted); end
    imem_rdata = 16'h0120;
    imem_ack   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      vectors++; if (imem_req !== 1'b0 || write_dst !== 2'b11) begin miscompares++; $display("FAIL halt_hold%0d got req=%b wd=%b exp 0,11", i, imem_req, write_dst); end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    vectors++; if (pc !== 16'h0000 || halted !== 1'b1) begin miscompares++; $display("FAIL halt_stuck got pc=%h halted=%b exp 0000,1", pc, halted); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_swap();
    test_mul();
    test_branch();
    test_illegal();
    test_pc_wrap();
    test_reset_mid_exec();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_seq_ctrl.md
Name: regfile_seq_ctrl

Overview:
- Multi-cycle sequencer for the 16x16 register file and ALU.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake and decodes them.
- Drives register-file read addresses and the 2-bit WriteDst write-enable code.
- Holds in EXEC for multi-cycle ALU ops (MUL/DIV) and resolves BEQ/JMP by updating the PC.

Parameters:
- PC_W, 16, program counter width.
- RESET_PC, 16'h0000, PC value loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (equals pc).
- imem_rdata  in  16  instruction word, valid when imem_ack=1.
- imem_ack  in  1  fetch complete; may arrive any cycle after imem_req.
- read_add1  out  4  register file ReadAdd1 (also destination register).
- read_add2  out  4  register file ReadAdd2.
- write_dst  out  2  WriteDst: 00 Rd, 01 Rd+Rs, 10 Rd+R15, 11 no write.
- data1  in  16  register file Data1.
- data15  in  16  register file Data15.
- alu_op  out  4  ALU function select.
- alu_start  out  1  one-cycle start pulse for multi-cycle ALU ops.
- alu_done  in  1  multi-cycle ALU op finished.
- pc  out  PC_W  current program counter.
- halted  out  1  sticky, set by HALT.
- illegal  out  1  sticky, set by undefined opcode.

Behaviour:
- Instruction format: [15:12] opcode, [11:8] op1 (Rd), [7:4] op2 (Rs), [3:0] funct. The instruction is latched into ir on fetch.
- Opcode map:
  - 0000 ALU: alu_op=funct. funct 0100 (MUL) and 0101 (DIV) are multi-cycle with write_dst=10; all other funct values are single-cycle with write_dst=00.
  - 1000 SWAP: write_dst=01.
  - 0100 BEQ: if data1==data15, pc <= pc + sign-extended ir[7:0]; else pc+1.
  - 1100 JMP: pc <= zero-extended ir[11:0].
  - 1111 HALT.
  - Any other opcode: set illegal and treat as NOP.
- Reset (async, rst=1): state=FETCH, pc=RESET_PC, ir=0, imem_req=0, read_add1=0, read_add2=0, write_dst=11, alu_op=0, alu_start=0, halted=0, illegal=0.
- State machine (one-hot or encoded, implementer's choice):
  - FETCH: imem_req=1, imem_addr=pc. Hold until imem_ack; then ir <= imem_rdata and go to DECODE. imem_req drops in the cycle after ack. Back-to-back acks are ignored outside FETCH.
  - DECODE (1 cycle): drive read_add1=ir[11:8], read_add2=ir[7:4], alu_op. ALU/SWAP go to EXEC. BEQ/JMP update pc and go to FETCH. HALT goes to HALT. Illegal opcode sets illegal, pc+1, FETCH.
  - EXEC:
    - Single-cycle op: 1 cycle, then WB.
    - MUL/DIV: alu_start pulses exactly on the first EXEC cycle, then wait for alu_done. If alu_done is already high on the start cycle it is accepted, giving minimum 1 cycle.
  - WB (1 cycle): write_dst=decoded code, read addresses held stable, pc <= pc+1, then FETCH.
  - HALT: halted=1, write_dst=11, imem_req=0. Exits only on reset.
- write_dst is 11 in every state except WB, so exactly one register-file write edge occurs per instruction.
- read_add1/read_add2 hold their values from DECODE through WB.
- PC arithmetic is modulo 2^PC_W: pc+1 at all-ones wraps to 0, and a BEQ negative offset wraps.
- Latency: single-cycle ALU/SWAP = fetch wait + 3 cycles. BEQ/JMP = fetch wait + 1.
- Reset asserted mid-fetch or mid-EXEC: immediate return to reset values. A pending imem_ack or alu_done arriving after reset is ignored until a new request is issued.
- Simultaneous rst and imem_ack: rst wins.

Decomposition:
- Shared package regfile_ctrl_pkg: opcode constants (OP_ALU, OP_SWAP, OP_BEQ, OP_JMP, OP_HALT), funct constants (FN_MUL, FN_DIV), WriteDst codes (WD_RD=00, WD_RD_RS=01, WD_RD_R15=10, WD_NONE=11), state enum.
- One sub-module: regfile_instr_decode (combinational). Input ir; outputs class, write_dst code, multicycle flag, illegal flag, branch offset.

Test Plan:
- Reset then instr 16'h0120 (ALU funct 0, Rd=1, Rs=2) acked after 2 cycles: WB occurs 3 cycles after ack with read_add1=1, read_add2=2, write_dst=00; pc 0->1.
- Instr 16'h8340 (SWAP R3,R4): single WB cycle with write_dst=01, read_add1=3, read_add2=4; write_dst=11 in all other cycles.
- Instr 16'h0564 (MUL) with alu_done after 5 cycles: alu_start high for exactly 1 cycle; write_dst=10 in the cycle after alu_done; pc+1.
- Instr 16'h41FE (BEQ R1, offset -2) at pc=5: data1=data15=16'h0F00 gives pc=3. Repeat with data1=16'h0F00, data15=0: pc=6.
- Instr 16'h2000: illegal=1, pc+1, no write. Instr 16'hF000: halted=1, imem_req stays 0 for 20 cycles.
- Assert rst during MUL wait, then pulse alu_done: pc=RESET_PC, state=FETCH, no write_dst!=11 observed, alu_done ignored.
